ifu_fetch: RTL
==============

# ifu_fetch

Instruction-fetch front end that consumes the next-PC selection and drives the instruction-memory request side of the CPU. It owns the architectural fetch PC register, issues one word fetch at a time to a handshaked instruction memory and presents each returned instruction, with its PC and PC+4, to decode. Redirects from the branch/jump path cancel any un-delivered fetch.

## Interface
- `RESET_PC`, default 32'h0000_3000, fetch PC loaded on reset.
- `clk` in 1, single clock; all state changes on the rising edge.
- `reset` in 1, asynchronous, active-low; 0 forces the reset state immediately.
- `redirect_valid` in 1, a non-sequential next PC is being supplied this cycle.
- `redirect_pc` in 32, redirect target from next-PC logic.
- `imem_req` out 1, fetch request.
- `imem_addr` out 32, word address of the request.
- `imem_gnt` in 1, memory accepts the request this cycle.
- `imem_rvalid` in 1, read data valid; at most one per grant, at least 1 cycle after the grant.
- `imem_rdata` in 32, instruction word.
- `if_valid` out 1, `if_instr`/`if_pc`/`if_pc4` hold a deliverable instruction.
- `if_ready` in 1, decode accepts when `if_valid & if_ready`.
- `if_instr` out 32, fetched instruction.
- `if_pc` out 32, address it was fetched from.
- `if_pc4` out 32, `if_pc + 4`.
- `addr_err` out 1, one-cycle pulse: the previous cycle's redirect target was misaligned.

## Operation
- Registers: `fetch_pc`, `state` (IDLE, REQ, WAIT, HOLD), `drop` flag, output registers.
- IDLE: entered only from reset; moves to REQ on the next edge.
- REQ: `imem_req=1` and `imem_addr=fetch_pc`.
  - On `imem_gnt`, go to WAIT.
  - Address changes before grant only through a redirect.
- WAIT: `imem_req=0`.
  - On `imem_rvalid` with `drop=0`: capture `if_instr=imem_rdata`, `if_pc=fetch_pc`, `if_pc4=fetch_pc+4`; set `fetch_pc=fetch_pc+4`; go to HOLD.
  - On `imem_rvalid` with `drop=1`: discard the data, clear `drop`, go to REQ.
- HOLD: `if_valid=1` and the outputs are stable.
  - When `if_ready=1`, the transfer completes and the next state is REQ.
  - Otherwise stay in HOLD.
- PC arithmetic is modulo 2^32. `fetch_pc=32'hFFFF_FFFC` increments to 0 with no flag.
- Redirect: on any cycle with `redirect_valid=1` (priority over sequential increment), `fetch_pc <= {redirect_pc[31:2],2'b00}`.
  - REQ, no grant: stay in REQ; the new address appears next cycle.
  - REQ with grant in the same cycle: go to WAIT with `drop=1` (the old-address response is discarded).
  - WAIT, no rvalid: set `drop=1` and stay in WAIT.
  - WAIT with rvalid in the same cycle: discard the data and go to REQ.
  - HOLD with `if_ready=1`: the transfer still completes (the redirect refers to younger instructions); go to REQ.
  - HOLD with `if_ready=0`: the held instruction is flushed (`if_valid` drops next cycle); go to REQ.
  - IDLE: `fetch_pc` is updated; go to REQ as normal.
- Misaligned redirect (`redirect_pc[1:0]!=0`): the target is truncated to word alignment and `addr_err=1` on the following cycle only.
- Never more than one outstanding request. `imem_rvalid` outside WAIT is ignored.

## Timing
- Reset values: `state=IDLE`, `fetch_pc=RESET_PC`, `drop=0`, `imem_req=0`, `if_valid=0`, `if_instr=0`, `if_pc=RESET_PC`, `if_pc4=RESET_PC+4`, `addr_err=0`.
- `imem_addr` equals `fetch_pc` at all times.
- All outputs are decoded from registers; there is no combinational path from any input to any output.
- Best-case latency, with grant in the REQ cycle and rvalid one cycle later:
  - cycle 1 after reset release: IDLE
  - cycle 2: REQ
  - cycle 3: WAIT with rvalid
  - cycle 4: `if_valid=1`
- Best-case throughput: one instruction per 3 cycles.
- Reset asserted mid-fetch abandons the transaction. Any later `imem_rvalid` for it arrives in IDLE/REQ and is ignored.

## Test plan
- Reset release, memory grants at once and returns `32'h3C01_1234` one cycle later -> `imem_addr=32'h3000` in cycle 2, `if_valid=1`, `if_pc=32'h3000`, `if_pc4=32'h3004` in cycle 4, next request to `32'h3004`.
- Decode holds `if_ready=0` for 5 cycles -> `if_instr`/`if_pc` stable and no `imem_req` during the stall; after acceptance the next request goes to `32'h3004`.
- Redirect to `32'h3100` while in WAIT, old data returns 2 cycles later -> old data never appears on `if_instr`; next `imem_addr=32'h3100`.
- Redirect to `32'h3200` in the same cycle as `imem_gnt` for `32'h3008` -> the `32'h3008` response is discarded; the next request is `32'h3200`.
- Redirect to `32'h3202` during HOLD with `if_ready=1` -> the held instruction is delivered once, `addr_err` pulses 1 cycle, next `imem_addr=32'h3200`. Repeat with `if_ready=0` -> the instruction is flushed and never accepted.
- Assert `reset` mid-WAIT, then `imem_rvalid` arrives -> `if_valid=0`, data ignored, fetch restarts at `32'h3000`.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: owns the fetch PC, issues one word fetch at a time
// to a handshaked instruction memory and hands each returned word to decode.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic        addr_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [1:0]  state_reg, state_next;
    logic [31:0] fetch_pc_reg, fetch_pc_next;
    logic        drop_reg, drop_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] pc4_reg, pc4_next;
    logic        addr_err_reg, addr_err_next;

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        drop_next     = drop_reg;
        instr_next    = instr_reg;
        pc_next       = pc_reg;
        pc4_next      = pc4_reg;
        addr_err_next = redirect_valid & (redirect_pc[1:0] != 2'b00);

        case (state_reg)
            IDLE: state_next = REQ;
            REQ: begin
                if (imem_gnt) begin
                    state_next = WAIT;
                    // A redirect racing the grant makes the granted response stale.
                    drop_next  = redirect_valid;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (drop_reg || redirect_valid) begin
                        drop_next  = 1'b0;
                        state_next = REQ;
                    end else begin
                        instr_next    = imem_rdata;
                        pc_next       = fetch_pc_reg;
                        pc4_next      = fetch_pc_reg + 32'd4;
                        fetch_pc_next = fetch_pc_reg + 32'd4;
                        state_next    = HOLD;
                    end
                end else if (redirect_valid) begin
                    drop_next = 1'b1;
                end
            end
            HOLD: begin
                // Either the transfer completes or a redirect flushes the held word.
                if (if_ready || redirect_valid) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase

        if (redirect_valid) begin
            fetch_pc_next = {redirect_pc[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
            drop_reg     <= 1'b0;
            instr_reg    <= 32'd0;
            pc_reg       <= RESET_PC;
            pc4_reg      <= RESET_PC + 32'd4;
            addr_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            drop_reg     <= drop_next;
            instr_reg    <= instr_next;
            pc_reg       <= pc_next;
            pc4_reg      <= pc4_next;
            addr_err_reg <= addr_err_next;
        end
    end

    assign imem_req  = (state_reg == REQ);
    assign imem_addr = fetch_pc_reg;
    assign if_valid  = (state_reg == HOLD);
    assign if_instr  = instr_reg;
    assign if_pc     = pc_reg;
    assign if_pc4    = pc4_reg;
    assign addr_err  = addr_err_reg;

endmodule
